// File: rtl/exception_unit_pkg.sv
// rtl/exception_unit_pkg.sv - shared mcause codes and helpers for the exception unit
//
// Purpose: one place for the machine-mode trap cause codes and the word
// alignment test used by the synchronous-exception prioritiser.
// Ports: none (package).
package exception_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] MCAUSE_INSTR_MISALIGN     = 32'd0;
  localparam logic [XLEN-1:0] MCAUSE_ILLEGAL_INSTR      = 32'd2;
  localparam logic [XLEN-1:0] MCAUSE_BREAKPOINT         = 32'd3;
  localparam logic [XLEN-1:0] MCAUSE_LOAD_MISALIGN      = 32'd4;
  localparam logic [XLEN-1:0] MCAUSE_LOAD_ACCESS_FAULT  = 32'd5;
  localparam logic [XLEN-1:0] MCAUSE_STORE_MISALIGN     = 32'd6;
  localparam logic [XLEN-1:0] MCAUSE_STORE_ACCESS_FAULT = 32'd7;
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M_MODE       = 32'd11;

  // There is no access-size input, so any nonzero byte offset within a
  // word counts as misaligned.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - synchronous exception detector and prioritiser
//
// Purpose: finds the single highest-priority synchronous exception for the
// current instruction and reports its mcause/mtval, both combinationally
// (same cycle) and through one register stage for the trap sequencer.
// Ports:
//   clk, rst_n                 core clock, synchronous active-low reset
//   pc, instruction            current instruction address and word
//   mem_addr                   effective load/store address
//   mem_read, mem_write        data access in progress
//   bus_error                  bus error on the current data access
//   illegal_instr, ecall, ebreak  decoder flags
//   exception_taken/cause/val  combinational result (cause/val 0 when none)
//   exc_valid_q/cause_q/val_q  registered copy, cleared by reset
module exception_unit
  import exception_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            bus_error,
  input  logic            illegal_instr,
  input  logic            ecall,
  input  logic            ebreak,
  output logic            exception_taken,
  output logic [XLEN-1:0] exception_cause,
  output logic [XLEN-1:0] exception_val,
  output logic            exc_valid_q,
  output logic [XLEN-1:0] exc_cause_q,
  output logic [XLEN-1:0] exc_val_q
);

  logic            exc_valid_d;
  logic [XLEN-1:0] exc_cause_d;
  logic [XLEN-1:0] exc_val_d;

  // Fixed priority, first match wins. Load checks precede store checks so
  // a cycle with both mem_read and mem_write reports the load fault. A bus
  // error with no data access in flight falls through and is ignored.
  always_comb begin
    exc_valid_d = 1'b1;
    exc_cause_d = '0;
    exc_val_d   = '0;
    if (word_misaligned(pc[1:0])) begin
      exc_cause_d = MCAUSE_INSTR_MISALIGN;
      exc_val_d   = pc;
    end else if (illegal_instr) begin
      exc_cause_d = MCAUSE_ILLEGAL_INSTR;
      exc_val_d   = instruction;
    end else if (ebreak) begin
      exc_cause_d = MCAUSE_BREAKPOINT;
      exc_val_d   = pc;
    end else if (mem_read && word_misaligned(mem_addr[1:0])) begin
      exc_cause_d = MCAUSE_LOAD_MISALIGN;
      exc_val_d   = mem_addr;
    end else if (mem_read && bus_error) begin
      exc_cause_d = MCAUSE_LOAD_ACCESS_FAULT;
      exc_val_d   = mem_addr;
    end else if (mem_write && word_misaligned(mem_addr[1:0])) begin
      exc_cause_d = MCAUSE_STORE_MISALIGN;
      exc_val_d   = mem_addr;
    end else if (mem_write && bus_error) begin
      exc_cause_d = MCAUSE_STORE_ACCESS_FAULT;
      exc_val_d   = mem_addr;
    end else if (ecall) begin
      exc_cause_d = MCAUSE_ECALL_M_MODE;
      exc_val_d   = '0;
    end else begin
      exc_valid_d = 1'b0;
    end
  end

  assign exception_taken = exc_valid_d;
  assign exception_cause = exc_cause_d;
  assign exception_val   = exc_val_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_val_q   <= '0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_val_q   <= exc_val_d;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - self-checking bench for exception_unit
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, instruction, mem_addr;
  logic        mem_read, mem_write, bus_error, illegal_instr, ecall, ebreak;
  logic        exception_taken;
  logic [31:0] exception_cause, exception_val;
  logic        exc_valid_q;
  logic [31:0] exc_cause_q, exc_val_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        taken;
    logic [31:0] cause;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  exception_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .bus_error(bus_error), .illegal_instr(illegal_instr), .ecall(ecall),
    .ebreak(ebreak), .exception_taken(exception_taken),
    .exception_cause(exception_cause), .exception_val(exception_val),
    .exc_valid_q(exc_valid_q), .exc_cause_q(exc_cause_q), .exc_val_q(exc_val_q)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Independent priority model for the random vectors.
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] a, input logic rd, input logic wr,
                                 input logic be, input logic ill, input logic ec,
                                 input logic eb);
    exp_t e;
    e.taken = 1'b1; e.cause = 32'd0; e.val = 32'd0;
    if (p[1:0] != 2'b00)            begin e.cause = 32'd0;  e.val = p;   end
    else if (ill)                   begin e.cause = 32'd2;  e.val = ins; end
    else if (eb)                    begin e.cause = 32'd3;  e.val = p;   end
    else if (rd && a[1:0] != 2'b00) begin e.cause = 32'd4;  e.val = a;   end
    else if (rd && be)              begin e.cause = 32'd5;  e.val = a;   end
    else if (wr && a[1:0] != 2'b00) begin e.cause = 32'd6;  e.val = a;   end
    else if (wr && be)              begin e.cause = 32'd7;  e.val = a;   end
    else if (ec)                    begin e.cause = 32'd11; e.val = 32'd0; end
    else e.taken = 1'b0;
    return e;
  endfunction

  // Drive one vector just after a rising edge, check the combinational
  // result, queue the registered expectation, then compare it after the edge.
  task automatic apply(input string tag, input logic [31:0] p, input logic [31:0] ins,
                       input logic [31:0] a, input logic rd, input logic wr,
                       input logic be, input logic ill, input logic ec, input logic eb,
                       input logic et, input logic [31:0] ecause, input logic [31:0] eval);
    exp_t q_exp, got;
    pc = p; instruction = ins; mem_addr = a; mem_read = rd; mem_write = wr;
    bus_error = be; illegal_instr = ill; ecall = ec; ebreak = eb;
    #1;
    check({tag, ".taken"}, {31'b0, exception_taken}, {31'b0, et});
    check({tag, ".cause"}, exception_cause, ecause);
    check({tag, ".val"}, exception_val, eval);
    if (rst_n) begin
      q_exp.taken = et; q_exp.cause = ecause; q_exp.val = eval;
    end else begin
      q_exp.taken = 1'b0; q_exp.cause = 32'd0; q_exp.val = 32'd0;
    end
    sb_q.push_back(q_exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check({tag, ".valid_q"}, {31'b0, exc_valid_q}, {31'b0, got.taken});
      check({tag, ".cause_q"}, exc_cause_q, got.cause);
      check({tag, ".val_q"}, exc_val_q, got.val);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] rp, ri, ra;
    logic [6:0]  rf;
    rst_n = 1'b0;
    pc = 32'h1000; instruction = 32'h0000_0013; mem_addr = 32'h0;
    mem_read = 0; mem_write = 0; bus_error = 0; illegal_instr = 0; ecall = 0; ebreak = 0;
    @(posedge clk); #1;

    // In reset: comb still reports, registers stay clear.
    apply("rst_ill", 32'h1000, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 1, 32'd2, 32'hDEADBEEF);
    apply("rst_ld",  32'h1000, 32'h13, 32'hCAFEBABC, 1, 0, 1, 0, 0, 0, 1, 32'd5, 32'hCAFEBABC);
    rst_n = 1'b1;

    apply("nop",     32'h1000, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    apply("pc1",     32'h1001, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h1001);
    apply("pc2",     32'h1002, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h1002);
    apply("pc3",     32'h1003, 32'h13, 0, 0, 0, 0, 1, 1, 1, 1, 32'd0, 32'h1003);
    apply("ill",     32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 1, 32'd2, 32'hDEADBEEF);
    apply("ill_eb",  32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 1, 32'd2, 32'hDEADBEEF);
    apply("ld_mis",  32'h1000, 32'h13, 32'h3001, 1, 0, 1, 0, 0, 0, 1, 32'd4, 32'h3001);
    apply("ld_acc",  32'h1000, 32'h13, 32'h3000, 1, 0, 1, 0, 0, 0, 1, 32'd5, 32'h3000);
    apply("ld_ok",   32'h1000, 32'h13, 32'h3000, 1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    apply("st_mis",  32'h1000, 32'h13, 32'h4002, 0, 1, 0, 0, 0, 0, 1, 32'd6, 32'h4002);
    apply("st_acc",  32'h1000, 32'h13, 32'hFFFFFFFC, 0, 1, 1, 0, 0, 0, 1, 32'd7, 32'hFFFFFFFC);
    apply("rw_acc",  32'h1000, 32'h13, 32'h2000, 1, 1, 1, 0, 0, 0, 1, 32'd5, 32'h2000);
    apply("rw_mis",  32'h1000, 32'h13, 32'h2003, 1, 1, 0, 0, 0, 0, 1, 32'd4, 32'h2003);
    apply("be_only", 32'h1000, 32'h13, 32'h2001, 0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    apply("ecall",   32'h5000, 32'h73, 0, 0, 0, 0, 0, 1, 0, 1, 32'd11, 32'd0);
    apply("ec_eb",   32'h5000, 32'h73, 0, 0, 0, 0, 0, 1, 1, 1, 32'd3, 32'h5000);
    apply("st_ec",   32'h5000, 32'h73, 32'h10, 0, 1, 1, 0, 1, 0, 1, 32'd7, 32'h10);
    // Misaligned load beats the bus error on the same access.
    apply("ld_cafe", 32'h1000, 32'h13, 32'hCAFEBABE, 1, 0, 1, 0, 0, 0, 1, 32'd4, 32'hCAFEBABE);
    apply("ld_cafc", 32'h1000, 32'h13, 32'hCAFEBABC, 1, 0, 1, 0, 0, 0, 1, 32'd5, 32'hCAFEBABC);

    for (int i = 0; i < 20; i++) begin
      rp = $urandom();
      if ($urandom_range(0, 1) == 1) rp[1:0] = 2'b00;
      ri = $urandom();
      ra = $urandom();
      rf = 7'($urandom());
      e = model(rp, ri, ra, rf[0], rf[1], rf[2], rf[3], rf[4], rf[5]);
      apply($sformatf("rnd%0d", i), rp, ri, ra, rf[0], rf[1], rf[2], rf[3], rf[4], rf[5],
            e.taken, e.cause, e.val);
      check($sformatf("rnd%0d.noX", i),
            {31'b0, $isunknown({exception_taken, exception_cause, exception_val,
                                exc_valid_q, exc_cause_q, exc_val_q})}, 32'd0);
    end

    // Reset asserted mid-run clears the registered copy.
    rst_n = 1'b0;
    apply("rst_mid", 32'h1001, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h1001);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
